// File: rtl/user_rom_arb_pkg.sv
// Shared constants for the user-domain pixel ROM arbiter: default parameters,
// FSM state encodings and an index-width helper.
package user_rom_arb_pkg;

  localparam int unsigned NUM_REQ_DEF   = 2;
  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BURST_DEF = 9;
  localparam int unsigned TIMEOUT_DEF   = 16;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Index width that stays at least one bit wide for a single requester
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/user_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module user_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  int unsigned       sum;
  logic [IdxW-1:0]   cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    sum     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      sum = 32'(ptr_i) + i;
      if (sum >= NumReq) sum = sum - NumReq;
      cand = IdxW'(sum);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/user_rom_arbiter.sv
// Shares one pixel ROM port between NumReq requesters: round-robin grant, burst lock,
// MaxBurst fairness cap and a response timeout guard with a sticky flag.
module user_rom_arbiter
  import user_rom_arb_pkg::*;
#(
  parameter  int unsigned NumReq        = NUM_REQ_DEF,
  parameter  int unsigned AddrWidth     = ADDR_W_DEF,
  parameter  int unsigned DataWidth     = DATA_W_DEF,
  parameter  int unsigned MaxBurst      = MAX_BURST_DEF,
  parameter  int unsigned TimeoutCycles = TIMEOUT_DEF,
  localparam int unsigned IdxW          = idx_width(NumReq)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]  addr_i,
  output logic [NumReq-1:0]                 valid_o,
  output logic [DataWidth-1:0]              data_o,
  output logic                              rom_req_o,
  output logic [AddrWidth-1:0]              rom_addr_o,
  input  logic [DataWidth-1:0]              rom_data_i,
  input  logic                              rom_valid_i,
  output logic                              busy_o,
  output logic [IdxW-1:0]                   owner_o,
  output logic                              timeout_o,
  input  logic                              clear_timeout_i
);

  localparam int unsigned BeatW = $clog2(MaxBurst + 1);
  localparam int unsigned WaitW = $clog2(TimeoutCycles);

  logic [0:0]       state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic [IdxW-1:0]  pick_idx;
  logic             pick_found;
  logic             in_access, beat, tmo;
  logic [IdxW-1:0]  next_ptr;

  user_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign in_access = (state_q == ST_ACCESS);
  assign rom_req_o = in_access & req_i[owner_q];
  assign beat      = rom_req_o & rom_valid_i;
  // A valid arriving on the last wait cycle counts as a beat, so it suppresses the timeout
  assign tmo       = rom_req_o & ~rom_valid_i & (wait_cnt_q == WaitW'(TimeoutCycles - 1));
  assign next_ptr  = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);

  assign busy_o    = in_access;
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

  // Zero-latency response path to the owner
  always_comb begin
    rom_addr_o = '0;
    valid_o    = '0;
    data_o     = '0;
    if (in_access) rom_addr_o = addr_i[owner_q];
    if (beat) begin
      valid_o[owner_q] = 1'b1;
      data_o           = rom_data_i;
    end else if (tmo) begin
      valid_o[owner_q] = 1'b1;
      data_o           = '1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = clear_timeout_i ? 1'b0 : timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!req_i[owner_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end else if (beat) begin
          wait_cnt_d = '0;
          if (beat_cnt_q != BeatW'(MaxBurst)) beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_cnt_q == BeatW'(MaxBurst - 1)) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (tmo) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          rr_ptr_d  = next_ptr;
        end else if (wait_cnt_q != {WaitW{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
